// File: rtl/alu32_pkg.sv
// Shared definitions for the alu32 datapath: FSM encoding, nibble width and a
// constant-function log2 used to size iteration counters.
package alu32_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int NIBBLE_W = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/nibble_sub4.sv
// Combinational 4-bit carry-lookahead slice. The parent pre-inverts b for
// subtraction, so this is a plain adder that also exposes the carry into bit 3.
module nibble_sub4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       c3,
    output logic       co
);

    logic [3:0] g;
    logic [3:0] p;
    logic       c1;
    logic       c2;

    assign g  = a & b;
    assign p  = a ^ b;
    assign c1 = g[0] | (p[0] & ci);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign co = g[3] | (p[3] & c3);
    assign s  = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/sub32_iter.sv
// Iterative subtractor: a - b computed as a + ~b + 1, one nibble per clock, LSB first.
// Optional macro SUB32_ITER_ADD_EN adds an 'op' port selecting add (op=1) or subtract.
//
// state   | meaning
// IDLE    | waiting for start; results hold
// RUN     | one nibble per cycle through the slice
// DONE    | publish difference and flags, pulse done
module sub32_iter
    import alu32_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef SUB32_ITER_ADD_EN
    input  logic             op,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             n,
    output logic             z,
    output logic             c,
    output logic             v
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int CNT_W = clog2(NIB);

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_width_check
        $error("sub32_iter: WIDTH must be a multiple of 4 and at least 8");
    end

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic             fin_c3;
    logic             fin_co;

    logic [NIBBLE_W-1:0] slice_s;
    logic                slice_c3;
    logic                slice_co;

    // Operands shift right each RUN cycle so the slice always sees the current nibble at [3:0].
    nibble_sub4 u_slice (
        .a  (opa[NIBBLE_W-1:0]),
        .b  (opb[NIBBLE_W-1:0]),
        .ci (carry),
        .s  (slice_s),
        .c3 (slice_c3),
        .co (slice_co)
    );

    // done stays in busy so busy covers the whole operation up to the result cycle.
    assign busy = (state != ST_IDLE) || done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            fin_c3 <= 1'b0;
            fin_co <= 1'b0;
            done   <= 1'b0;
            d      <= '0;
            n      <= 1'b0;
            z      <= 1'b0;
            c      <= 1'b0;
            v      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        opa <= a;
`ifdef SUB32_ITER_ADD_EN
                        opb   <= op ? b : ~b;
                        carry <= ~op;
`else
                        opb   <= ~b;
                        carry <= 1'b1;
`endif
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc   <= {slice_s, acc[WIDTH-1:NIBBLE_W]};
                    opa   <= opa >> NIBBLE_W;
                    opb   <= opb >> NIBBLE_W;
                    carry <= slice_co;
                    if (cnt == CNT_W'(NIB - 1)) begin
                        fin_c3 <= slice_c3;
                        fin_co <= slice_co;
                        state  <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    d     <= acc;
                    n     <= acc[WIDTH-1];
                    z     <= (acc == '0);
                    c     <= fin_co;
                    v     <= fin_c3 ^ fin_co;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sub32_iter.sv
// Directed bench for sub32_iter: hand-computed vectors, latency/busy/done-pulse
// checks, mid-run disturbance and reset abort. Define SUB32_ITER_ADD_EN for add vectors.
module tb_sub32_iter;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] d;
    logic        n;
    logic        z;
    logic        c;
    logic        v;
`ifdef SUB32_ITER_ADD_EN
    logic        op;
`endif

    int checks;
    int errors;

    sub32_iter #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
`ifdef SUB32_ITER_ADD_EN
        .op    (op),
`endif
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .n     (n),
        .z     (z),
        .c     (c),
        .v     (v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_res(input string tag, input logic [31:0] ed, input logic en,
                             input logic ez, input logic ec, input logic ev);
        check_val({tag, ".d"}, d, ed);
        check_val({tag, ".n"}, {31'd0, n}, {31'd0, en});
        check_val({tag, ".z"}, {31'd0, z}, {31'd0, ez});
        check_val({tag, ".c"}, {31'd0, c}, {31'd0, ec});
        check_val({tag, ".v"}, {31'd0, v}, {31'd0, ev});
    endtask

    // Issues one operation and watches a fixed 30-edge window after the start edge.
    // mid=1 re-asserts start and scrambles a/b during RUN cycle 3.
    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tbv,
                          input logic top, input bit mid);
        int lat;
        int busy_cnt;
        int pulses;
        lat      = 0;
        busy_cnt = 0;
        pulses   = 0;
        @(negedge clk);
        a     = ta;
        b     = tbv;
        start = 1'b1;
`ifdef SUB32_ITER_ADD_EN
        op = top;
`else
        if (top) $display("note: op=1 requested without add support");
`endif
        @(posedge clk);
        #1;
        if (busy) busy_cnt++;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (busy) busy_cnt++;
            if (done) begin
                pulses++;
                if (lat == 0) lat = i;
            end
            if (mid && i == 2) begin
                @(negedge clk);
                start = 1'b1;
                a     = 32'hDEADBEEF;
                b     = 32'h00001234;
            end
            if (mid && i == 3) begin
                @(negedge clk);
                start = 1'b0;
            end
        end
        check_val({tag, ".latency"}, lat, 32'd9);
        check_val({tag, ".busy_cycles"}, busy_cnt, 32'd10);
        check_val({tag, ".done_pulses"}, pulses, 32'd1);
    endtask

    initial begin
        int pulses;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
`ifdef SUB32_ITER_ADD_EN
        op = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_val("rst.busy", {31'd0, busy}, 32'd0);
        check_val("rst.done", {31'd0, done}, 32'd0);
        check_res("rst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        run_op("sub5_3", 32'd5, 32'd3, 1'b0, 1'b0);
        check_res("sub5_3", 32'h00000002, 1'b0, 1'b0, 1'b1, 1'b0);

        run_op("minneg", 32'h80000000, 32'd1, 1'b0, 1'b0);
        check_res("minneg", 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1);

        run_op("zero_m1", 32'd0, 32'd1, 1'b0, 1'b0);
        check_res("zero_m1", 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0);

        // Results must hold while idle.
        repeat (5) @(posedge clk);
        #1;
        check_res("hold", 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0);

        run_op("sub7_7", 32'd7, 32'd7, 1'b0, 1'b1);
        check_res("sub7_7", 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0);

        // Reset abort during RUN cycle 4.
        @(negedge clk);
        a     = 32'h12345678;
        b     = 32'd1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("abort.busy", {31'd0, busy}, 32'd0);
        check_val("abort.done", {31'd0, done}, 32'd0);
        check_res("abort", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check_val("abort.no_done", pulses, 32'd0);

`ifdef SUB32_ITER_ADD_EN
        run_op("add_wrap", 32'hFFFFFFFF, 32'd1, 1'b1, 1'b0);
        check_res("add_wrap", 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0);
        run_op("add_ovf", 32'h7FFFFFFF, 32'd1, 1'b1, 1'b0);
        check_res("add_ovf", 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b1);
        run_op("sub_again", 32'd5, 32'd3, 1'b0, 1'b0);
        check_res("sub_again", 32'h00000002, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
